shift_serializer: RTL and testbench

//   Parallel-to-serial front end: accepts an N-bit word over a valid/ready handshake.

---
 rtl/shift_pkg.sv | 16 +
 rtl/univ_shift_reg.sv | 35 +++
 rtl/shift_serializer.sv | 79 +++++++
 tb/tb_shift_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the parallel-to-serial front end: shift-register control codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHL  = 2'b01,
    SR_SHR  = 2'b10,
    SR_LOAD = 2'b11
  } sr_ctrl_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold, shift left, shift right or parallel load.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  sr_ctrl_t     ctrl,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Serial fill comes from d[0] on left shifts and d[N-1] on right shifts.
  always_comb begin
    q_d = q_q;
    case (ctrl)
      SR_SHL:  q_d = {q_q[N-2:0], d[0]};
      SR_SHR:  q_d = {d[N-1], q_q[N-1:1]};
      SR_LOAD: q_d = d;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial front end: accepts a word over valid/ready and streams it one bit per
// cycle, MSB- or LSB-first, with zero-gap back-to-back words.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         lsb_first,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N);

  ser_state_t    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          dir_q, dir_d;
  sr_ctrl_t      sr_ctrl;
  logic [N-1:0]  sr_d;
  logic [N-1:0]  sr_q;
  logic          accept;

  univ_shift_reg #(.N(N)) u_sreg (
    .clk   (clk),
    .reset (~reset),
    .ctrl  (sr_ctrl),
    .d     (sr_d),
    .q     (sr_q)
  );

  // Stream outputs depend only on state, shift register, counter and ser_ready.
  assign busy      = (state_q == S_SHIFT);
  assign ser_valid = busy;
  assign ser_last  = busy && (bit_cnt_q == CW'(N - 1));
  assign ser_out   = busy && (dir_q ? sr_q[0] : sr_q[N-1]);
  assign in_ready  = !busy || (ser_last && ser_ready);
  assign accept    = in_valid && in_ready;

  // Load beats shift, so a word arriving on the last-bit transfer follows with no gap.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dir_d     = dir_q;
    sr_ctrl   = SR_HOLD;
    sr_d      = '0;
    if (accept) begin
      sr_ctrl   = SR_LOAD;
      sr_d      = in_data;
      dir_d     = lsb_first;
      bit_cnt_d = '0;
      state_d   = S_SHIFT;
    end else if (busy && ser_ready) begin
      sr_ctrl = dir_q ? SR_SHR : SR_SHL;
      if (ser_last) state_d   = S_IDLE;
      else          bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: queue-of-bits reference model checked every cycle,
// plus directed words whose captured streams are compared against hand-computed literals.
module tb_shift_serializer;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         lsb_first = 1'b0;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready = 1'b1;
  logic         ser_last;
  logic         busy;

  shift_serializer #(.N(N)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lsb_first (lsb_first),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending serial stream as a queue of (bit, last) pairs.
  typedef struct packed { logic b; logic last; } sbit_t;
  sbit_t model_q[$];

  logic [63:0] cap_bits;
  int          cap_n;
  int          last_cnt;
  int          last_pos;
  int          valid_cycles;

  // Checks outputs mid-cycle, then advances the model to what the next rising edge does.
  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    if (!rst_n) begin
      model_q.delete();
      chk("rst_in_ready",  64'(in_ready),  64'(1'b1));
      chk("rst_ser_valid", 64'(ser_valid), 64'(1'b0));
      chk("rst_ser_last",  64'(ser_last),  64'(1'b0));
      chk("rst_busy",      64'(busy),      64'(1'b0));
      chk("rst_ser_out",   64'(ser_out),   64'(1'b0));
    end else begin
      exp_valid = (model_q.size() != 0);
      exp_ready = (model_q.size() == 0) || (model_q.size() == 1 && ser_ready);
      chk("ser_valid", 64'(ser_valid), 64'(exp_valid));
      chk("in_ready",  64'(in_ready),  64'(exp_ready));
      chk("busy",      64'(busy),      64'(exp_valid));
      if (exp_valid) begin
        chk("ser_out",  64'(ser_out),  64'(model_q[0].b));
        chk("ser_last", 64'(ser_last), 64'(model_q[0].last));
      end
      if (ser_valid) valid_cycles++;
      if (ser_valid && ser_ready) begin
        cap_bits = {cap_bits[62:0], ser_out};
        cap_n++;
        if (ser_last) begin
          last_cnt++;
          last_pos = cap_n;
        end
      end
      if (exp_valid && ser_ready) void'(model_q.pop_front());
      if (in_valid && exp_ready) begin
        for (int i = 0; i < int'(N); i++) begin
          sbit_t e;
          e.b    = lsb_first ? in_data[i] : in_data[int'(N) - 1 - i];
          e.last = (i == int'(N) - 1);
          model_q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_bits     = '0;
    cap_n        = 0;
    last_cnt     = 0;
    last_pos     = 0;
    valid_cycles = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 64'(done), 64'(1'b1));
  endtask

  task automatic send_word(input logic [N-1:0] data, input logic lsb);
    in_valid  = 1'b1;
    in_data   = data;
    lsb_first = lsb;
    tick();
    in_valid  = 1'b0;
    lsb_first = ~lsb;
  endtask

  initial begin
    clear_cap();
    // 1: reset held two cycles, then released
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t1_in_ready",  64'(in_ready),         64'(1'b1));
    chk("t1_ser_valid", 64'(ser_valid),        64'(1'b0));
    chk("t1_busy",      64'(busy),             64'(1'b0));
    chk("t1_q",         64'(dut.u_sreg.q_q),   64'(0));

    // 2: 8'h1E MSB-first
    clear_cap();
    send_word(8'h1E, 1'b0);
    wait_idle();
    chk("t2_bits",  cap_bits,            64'h1E);
    chk("t2_n",     64'(cap_n),          64'(8));
    chk("t2_lastn", 64'(last_cnt),       64'(1));
    chk("t2_lastp", 64'(last_pos),       64'(8));

    // 3: 8'h1E LSB-first -> 0,1,1,1,1,0,0,0
    clear_cap();
    send_word(8'h1E, 1'b1);
    wait_idle();
    chk("t3_bits",  cap_bits,            64'h78);
    chk("t3_lastn", 64'(last_cnt),       64'(1));
    chk("t3_lastp", 64'(last_pos),       64'(8));

    // 4: back-to-back 8'h05 then 8'h0A, in_valid held
    clear_cap();
    in_valid = 1'b1; in_data = 8'h05; lsb_first = 1'b0;
    tick();
    in_data = 8'h0A;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        break;
      end
      tick();
    end
    wait_idle();
    chk("t4_bits",   cap_bits,            64'h050A);
    chk("t4_valid",  64'(valid_cycles),   64'(16));
    chk("t4_lastn",  64'(last_cnt),       64'(2));

    // 5: 8'hA5 MSB-first, 3-cycle stall at bit 4 with ignored in_valid pulses
    clear_cap();
    send_word(8'hA5, 1'b0);
    repeat (4) tick();
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid;
      in_data  = 8'hFF;
      chk("t5_hold_out", 64'(ser_out), 64'(1'b0));
      tick();
    end
    chk("t5_hold_out_end", 64'(ser_out), 64'(1'b0));
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    wait_idle();
    chk("t5_bits",  cap_bits,          64'hA5);
    chk("t5_valid", 64'(valid_cycles), 64'(11));

    // 6: reset at bit 5 of 8'hFF, then 8'h81
    clear_cap();
    send_word(8'hFF, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(ser_valid), 64'(1'b0));
    chk("t6_async_ready", 64'(in_ready),  64'(1'b1));
    tick();
    chk("t6_no_last", 64'(last_cnt), 64'(0));
    rst_n = 1'b1;
    tick();
    clear_cap();
    send_word(8'h81, 1'b0);
    wait_idle();
    chk("t6_bits", cap_bits, 64'h81);
    chk("t6_n",    64'(cap_n), 64'(8));

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = N'($urandom);
      lsb_first = 1'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
